multicycle_controller: RTL

Parametrised multi-cycle successor to the single-cycle instruction decoder. It fetches instructions over a valid/ready memory handshake and latches them in an internal instruction register (IR). Each instruction is sequenced through FETCH/DECODE/EXEC/MEM/WB states, and the controller emits per-state strobes to the PC, register file, ALU and data memory. It sits between instruction/data memory and the datapath, and supports a two-word ADDI (opcode word followed by an immediate word) plus stall-on-memory.

---
 rtl/multicycle_controller_if.sv | 47 ++++
 rtl/multicycle_controller.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Controller <-> memory/datapath bundle plus the shared ALU operation encoding.
// master = controller side, slave = memories and datapath.
package mc_pkg;
    typedef enum logic [2:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT
    } e_alu_op;
endpackage

interface multicycle_controller_if #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 4,
    parameter int REG_W  = 2
);
    import mc_pkg::*;

    logic [WORD_W-1:0] instr_data;
    logic              instr_valid;
    logic              mem_ready;
    logic              zero;
    logic              instr_req;
    logic              pc_en;
    logic              pc_src;
    logic [OP_W-1:0]   ir_op;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic              imm_en;
    logic [WORD_W-1:0] imm;
    e_alu_op           alu_op;
    logic              alu_src;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_to_reg;
    logic              reg_wr;
    logic              illegal;

    modport master (
        input  instr_data, instr_valid, mem_ready, zero,
        output instr_req, pc_en, pc_src, ir_op, rs, rt, imm_en, imm, alu_op,
               alu_src, mem_rd, mem_wr, mem_to_reg, reg_wr, illegal
    );

    modport slave (
        output instr_data, instr_valid, mem_ready, zero,
        input  instr_req, pc_en, pc_src, ir_op, rs, rt, imm_en, imm, alu_op,
               alu_src, mem_rd, mem_wr, mem_to_reg, reg_wr, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/IMM/EXEC/MEM/WB sequencer with instruction register.
// CTRL_ILLEGAL_TRAP_EN: opcodes above ZERO lock the controller in TRAP and set illegal.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int OP_W   = 4,
    parameter int REG_W  = 2
) (
    input logic clk,
    input logic rst,
    multicycle_controller_if.master bus
);
    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_RO   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_COPY = OP_W'(11);
    localparam logic [OP_W-1:0] OP_JEQ  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_ZERO = OP_W'(13);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_IMM, S_EXEC, S_MEM, S_WB, S_TRAP
    } e_state;

    e_state            state, state_d;
    logic [WORD_W-1:0] ir, imm_q;
    logic [OP_W-1:0]   op;

    assign op       = ir[WORD_W-1 -: OP_W];
    assign bus.ir_op = op;
    assign bus.rs   = ir[2*REG_W-1 -: REG_W];
    assign bus.rt   = ir[REG_W-1:0];
    assign bus.imm  = imm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            ir    <= '0;
            imm_q <= '0;
        end else begin
            state <= state_d;
            if (state == S_FETCH && bus.instr_valid) ir <= bus.instr_data;
            if (bus.imm_en) imm_q <= bus.instr_data;
        end
    end

    always_comb begin
        state_d        = state;
        bus.instr_req  = 1'b0;
        bus.pc_en      = 1'b0;
        bus.pc_src     = 1'b0;
        bus.imm_en     = 1'b0;
        bus.alu_op     = ALU_NOP;
        bus.alu_src    = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_wr     = 1'b0;
        case (state)
            S_FETCH: begin
                bus.instr_req = 1'b1;
                if (bus.instr_valid) begin
                    bus.pc_en = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_ADDI:                                   state_d = S_IMM;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
                    OP_JEQ:                                    state_d = S_EXEC;
                    OP_LW, OP_SW:                              state_d = S_MEM;
                    OP_RO, OP_COPY:                            state_d = S_WB;
                    default:                                   state_d = S_FETCH;
                endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (op > OP_ZERO) state_d = S_TRAP;
`endif
            end
            S_IMM: begin
                bus.instr_req = 1'b1;
                if (bus.instr_valid) begin
                    bus.imm_en = 1'b1;
                    bus.pc_en  = 1'b1;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_ADDI: bus.alu_op = ALU_ADD;
                    OP_SUB, OP_JEQ:  bus.alu_op = ALU_SUB;
                    OP_AND:          bus.alu_op = ALU_AND;
                    OP_OR:           bus.alu_op = ALU_OR;
                    OP_NOT:          bus.alu_op = ALU_NOT;
                    default:         bus.alu_op = ALU_NOP;
                endcase
                bus.alu_src = (op == OP_ADDI);
                if (op == OP_JEQ) begin
                    // branch taken only when the SUB compare came out zero
                    bus.pc_en  = bus.zero;
                    bus.pc_src = bus.zero;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                bus.mem_rd = (op == OP_LW);
                bus.mem_wr = (op == OP_SW);
                if (bus.mem_ready) state_d = (op == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB: begin
                bus.reg_wr     = 1'b1;
                bus.mem_to_reg = (op == OP_LW);
                state_d        = S_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   illegal_q <= 1'b0;
        else if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif
endmodule
